// File: rtl/pll_reset_sequencer.sv
// Core reset sequencer for the PLL clock domain: waits for a stable PLL lock, holds the core in
// reset, then releases it. Optional lock-loss counter guarded by PLL_RESET_LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned LOSS_COUNT_WIDTH   = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        pll_locked,
  input  logic                        soft_reset_req,
  output logic                        core_reset_n,
  output logic                        clock_ready,
  output logic [1:0]                  state,
  output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count
);

  localparam int unsigned MaxCycles = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                      LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);

  localparam logic [CntWidth-1:0] StableLast = CntWidth'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntWidth-1:0] HoldLast   = CntWidth'(RESET_HOLD_CYCLES - 1);
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);

  typedef enum logic [1:0] {
    StWaitLock  = 2'd0,
    StStabilize = 2'd1,
    StHold      = 2'd2,
    StRun       = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   fsm_en;
  logic                   locked_s;

  state_e                 state_q;
  logic [CntWidth-1:0]    cnt_q;
  logic                   run_q;

  // Reset release and lock indicator both pass through SYNC_STAGES flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign fsm_en   = rst_sync_q[SYNC_STAGES-1];
  assign locked_s = lock_sync_q[SYNC_STAGES-1];

  // run_q is loaded with (next state == RUN) on every transition so the core reset and
  // clock_ready change on the very edge that enters or leaves RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (fsm_en) begin
      unique case (state_q)
        StWaitLock: begin
          if (locked_s) begin
            state_q <= StStabilize;
            cnt_q   <= '0;
          end
        end
        StStabilize: begin
          if (!locked_s) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == StableLast) begin
            state_q <= StHold;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHold: begin
          if (!locked_s) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == HoldLast) begin
            state_q <= StRun;
            cnt_q   <= '0;
            run_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRun: begin
          // Lock loss takes priority over a simultaneous soft reset request.
          if (!locked_s) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            run_q   <= 1'b0;
          end else if (soft_reset_req) begin
            state_q <= StHold;
            cnt_q   <= '0;
            run_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign core_reset_n = run_q;
  assign clock_ready  = run_q;
  assign state        = state_q;

`ifdef PLL_RESET_LOCK_LOSS_COUNT_EN
  logic                        loss_event;
  logic [LOSS_COUNT_WIDTH-1:0] loss_cnt_q;

  assign loss_event = fsm_en & (state_q == StRun) & ~locked_s;

  // Saturating count of lock losses observed while running.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q <= '0;
    end else if (loss_event && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + LOSS_COUNT_WIDTH'(1);
    end
  end

  assign lock_loss_count = loss_cnt_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL wrapper and runs in the PLL output clock domain.
- Watches the PLL lock indicator, which is asynchronous to this domain.
- Holds the processor core in reset until lock has been continuously stable for a programmable time, then releases a clean synchronous-deassert reset.
- On loss of lock, re-asserts the core reset and restarts the sequence. Also supports a core-requested soft reset.

Parameters:
- SYNC_STAGES, 2: flop count of the pll_locked synchronizer and of the reset_n release synchronizer (≥2).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles locked_s must stay high before the reset hold begins (≥1).
- RESET_HOLD_CYCLES, 16: cycles core_reset_n stays low after lock is deemed stable (≥1).
- LOSS_COUNT_WIDTH, 8: width of the lock-loss event counter.

Ports:
- clock, input, 1: PLL output clock (from Pll.clock_out).
- reset_n, input, 1: asynchronous active-low reset. Asserts asynchronously; release is synchronized internally.
- pll_locked, input, 1: PLL lock indicator, asynchronous to clock.
- soft_reset_req, input, 1: synchronous single-cycle request from the core to re-run the hold phase.
- core_reset_n, output, 1: active-low reset to the core. Registered.
- clock_ready, output, 1: high only in RUN. Registered.
- state, output, 2: current FSM state, for debug.
- lock_loss_count, output, LOSS_COUNT_WIDTH: number of lock losses seen in RUN.

Behaviour:
- Reset:
  - reset_n low asynchronously forces state=WAIT_LOCK(0), core_reset_n=0, clock_ready=0, lock_loss_count=0, counter=0, and all synchronizer flops to 0.
  - Reset is released internally through a SYNC_STAGES-flop chain, so the FSM first acts SYNC_STAGES edges after reset_n rises.
  - reset_n asserting mid-operation (any state) takes immediate asynchronous effect.
- Synchronizer: locked_s is pll_locked delayed through SYNC_STAGES flops. Only locked_s is used internally.
- Counter: a single shared counter, width $clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)+1). It clears on every state change.
- State encoding: WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3.
- WAIT_LOCK: if locked_s=1, go to STABILIZE.
- STABILIZE:
  - locked_s=0: go to WAIT_LOCK (not counted as a loss).
  - locked_s=1: counter++. When counter==LOCK_STABLE_CYCLES-1, go to HOLD. STABILIZE therefore lasts exactly LOCK_STABLE_CYCLES cycles.
- HOLD:
  - locked_s=0: go to WAIT_LOCK (not counted as a loss).
  - Otherwise counter++. When counter==RESET_HOLD_CYCLES-1, go to RUN.
  - soft_reset_req is ignored in HOLD.
- RUN:
  - locked_s=0: go to WAIT_LOCK and increment lock_loss_count, saturating at all-ones.
  - soft_reset_req=1 with locked_s=1: go to HOLD.
  - Both in the same cycle: lock loss wins and the request is dropped.
- Outputs:
  - core_reset_n and clock_ready are flops loaded with (next_state==RUN). They rise on the same edge that enters RUN and fall on the same edge that leaves it.
- Latency:
  - Count edge 1 as the first edge sampling pll_locked=1.
  - core_reset_n rises at edge SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES.
  - pll_locked falling in RUN drops core_reset_n at edge SYNC_STAGES+1.
- Glitches: a pll_locked high pulse shorter than LOCK_STABLE_CYCLES never releases core reset.

Optional Feature:
- Macro: PLL_RESET_LOCK_LOSS_COUNT_EN.
- Defined: lock_loss_count is implemented as specified above.
- Undefined: no counter register exists. lock_loss_count is tied to 0. The port is still present, so integration is unchanged.

Test Plan:
All tests use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4 unless stated.
1. Power-up: reset_n released, pll_locked=1 from edge 1 → core_reset_n and clock_ready rise at edge 15 and are 0 before it. State sequence is 0,1,2,3.
2. Lock glitch: pll_locked high 5 cycles, low 3, then high → the first pulse never reaches HOLD. core_reset_n rises 15 edges after the final rise. lock_loss_count=0.
3. Loss in RUN: after core_reset_n=1, drop pll_locked → core_reset_n=0 at edge 3 after the drop, state=0, lock_loss_count=1. Re-lock → run again after 15 edges.
4. Soft reset: in RUN, soft_reset_req=1 for one cycle → core_reset_n low for exactly 4 cycles, then high. lock_loss_count unchanged.
5. Simultaneous: soft_reset_req=1 in the same cycle locked_s falls → state goes to WAIT_LOCK and lock_loss_count increments. Also: with LOSS_COUNT_WIDTH=2, 5 losses → count saturates at 3.
6. Async reset mid-STABILIZE: pull reset_n low between clock edges → all outputs 0 immediately. After release, the sequence restarts with full latency; with the macro undefined, lock_loss_count stays 0 throughout.
